// File: rtl/bsg_mul_pipelined_ctrl.sv
// Valid/ready in, valid/yumi out flow control around a stall-only pipelined multiplier.
// Tracks per-stage valids, collapses bubbles, and holds each product until it is taken.
module bsg_mul_pipelined_ctrl #(
   parameter int width_p    = 128,
   parameter int pipeline_p = 3,
   localparam int inflight_w_lp = $clog2(pipeline_p + 2)
) (
   input  logic                       clock_i,
   input  logic                       reset_n_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [width_p-1:0]         x_i,
   input  logic [width_p-1:0]         y_i,
   input  logic                       signed_i,
   output logic                       mul_en_o,
   output logic [width_p-1:0]         mul_x_o,
   output logic [width_p-1:0]         mul_y_o,
   output logic                       mul_signed_o,
   input  logic [2*width_p-1:0]       mul_z_i,
   output logic                       v_o,
   output logic [2*width_p-1:0]       z_o,
   input  logic                       yumi_i,
   output logic [inflight_w_lp-1:0]   inflight_o
);

   logic [pipeline_p-1:0]     r_vld;
   logic                      r_v;
   logic [2*width_p-1:0]      r_z;
   logic [inflight_w_lp-1:0]  r_inflight;

   logic [pipeline_p-1:0]     w_vld_next;
   logic                      w_last;
   logic                      w_adv;
   logic                      w_accept;
   logic                      w_take;

   // The pipe may move unless a finished op sits in the last stage with nowhere to go.
   assign w_last   = r_vld[pipeline_p-1];
   assign w_adv    = reset_n_i & (~r_v | yumi_i | ~w_last);
   assign w_accept = v_i & w_adv;
   assign w_take   = yumi_i & r_v;

   assign ready_o      = w_adv;
   assign mul_en_o     = w_adv;
   assign mul_x_o      = x_i;
   assign mul_y_o      = y_i;
   assign mul_signed_o = signed_i;
   assign v_o          = r_v;
   assign z_o          = r_z;
   assign inflight_o   = r_inflight;

   always_comb begin
      w_vld_next    = r_vld << 1;
      w_vld_next[0] = w_accept;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         r_vld      <= '0;
         r_v        <= 1'b0;
         r_z        <= '0;
         r_inflight <= '0;
      end else begin
         if (w_adv) begin
            r_vld <= w_vld_next;
         end
         // A product arriving in the same cycle as a take refills the output register.
         if (w_adv & w_last) begin
            r_z <= mul_z_i;
            r_v <= 1'b1;
         end else if (w_take) begin
            r_v <= 1'b0;
         end
         if (w_accept & ~w_take) begin
            r_inflight <= r_inflight + inflight_w_lp'(1);
         end else if (~w_accept & w_take) begin
            r_inflight <= r_inflight - inflight_w_lp'(1);
         end
      end
   end

endmodule

// File: tb/tb_bsg_mul_pipelined_ctrl.sv
// Bench for bsg_mul_pipelined_ctrl: multiplier stub, directed scenarios, random traffic,
// scoreboard of expected products in acceptance order.
module tb_bsg_mul_pipelined_ctrl;

   localparam int W    = 128;
   localparam int PIPE = 3;
   localparam int CW   = $clog2(PIPE + 2);

   logic            clk = 1'b0;
   logic            reset_n_i;
   logic            v_i;
   logic            ready_o;
   logic [W-1:0]    x_i, y_i;
   logic            signed_i;
   logic            mul_en_o;
   logic [W-1:0]    mul_x_o, mul_y_o;
   logic            mul_signed_o;
   logic [2*W-1:0]  mul_z_i;
   logic            v_o;
   logic [2*W-1:0]  z_o;
   logic            yumi_i;
   logic [CW-1:0]   inflight_o;

   bsg_mul_pipelined_ctrl #(.width_p(W), .pipeline_p(PIPE)) dut (
      .clock_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
      .x_i(x_i), .y_i(y_i), .signed_i(signed_i), .mul_en_o(mul_en_o),
      .mul_x_o(mul_x_o), .mul_y_o(mul_y_o), .mul_signed_o(mul_signed_o),
      .mul_z_i(mul_z_i), .v_o(v_o), .z_o(z_o), .yumi_i(yumi_i),
      .inflight_o(inflight_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      logic [2*W-1:0] ae, be;
      ae = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      be = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ae * be;
   endfunction

   // Stall-only multiplier stub: advances only on enabled edges.
   logic [2*W-1:0] stg [PIPE];
   initial for (int i = 0; i < PIPE; i++) stg[i] = '0;
   always @(posedge clk) begin
      if (mul_en_o) begin
         for (int i = PIPE - 1; i > 0; i--) stg[i] <= stg[i-1];
         stg[0] <= ref_mul(mul_x_o, mul_y_o, mul_signed_o);
      end
   end
   assign mul_z_i = stg[PIPE-1];

   // ---------------- checking ----------------
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [2*W-1:0] exp_q[$];
   int             model_cnt = 0;
   int             n_acc = 0;
   int             n_pop = 0;
   logic [2*W-1:0] last_z = '0;
   logic [2*W-1:0] prev_z = '0;
   bit             hold_prev = 0;
   bit             mon_en = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         chk("inflight", inflight_o, model_cnt);
         chk("en_eq_ready", mul_en_o, ready_o);
         chk("mul_x", mul_x_o, x_i);
         chk("mul_y", mul_y_o, y_i);
         chk("mul_signed", mul_signed_o, signed_i);
         if (!reset_n_i) begin
            chk("rst_ready", ready_o, 0);
            exp_q.delete();
            model_cnt = 0;
            hold_prev = 0;
         end else begin
            if (!v_o)   chk("ready_out_empty", ready_o, 1);
            if (yumi_i) chk("ready_on_yumi", ready_o, 1);
            if (model_cnt == PIPE + 1 && !yumi_i) chk("ready_full", ready_o, 0);
            if (hold_prev) begin
               chk("hold_v", v_o, 1);
               chk("hold_z", z_o, prev_z);
            end
            if (v_i && ready_o) begin
               exp_q.push_back(ref_mul(x_i, y_i, signed_i));
               model_cnt++;
               n_acc++;
            end
            if (yumi_i && v_o) begin
               chk("out_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) chk("product", z_o, exp_q.pop_front());
               last_z = z_o;
               model_cnt--;
               n_pop++;
            end
            hold_prev = v_o && !yumi_i;
            prev_z    = z_o;
         end
      end
   end

   // ---------------- drivers ----------------
   // yumi policy: 0 take whenever valid, 1 never, 2 random, 3 every other cycle
   int yumi_mode = 1;
   bit pulse_t   = 0;
   always @(posedge clk) begin
      #1;
      case (yumi_mode)
         0: yumi_i = v_o;
         2: yumi_i = v_o & ($urandom_range(0, 1) == 1);
         3: begin pulse_t = ~pulse_t; yumi_i = v_o & pulse_t; end
         default: yumi_i = 1'b0;
      endcase
      if (!reset_n_i) yumi_i = 1'b0;
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                          output int waited, output int acc_cyc);
      v_i = 1'b1; x_i = x; y_i = y; signed_i = s;
      waited = 0;
      while (!ready_o && waited < 40) begin
         step();
         waited++;
      end
      if (!ready_o) chk("accept_timeout", waited, 0);
      acc_cyc = cyc;
      step();
      v_i = 1'b0;
   endtask

   task automatic wait_vo(output int n);
      n = 0;
      while (!v_o && n < 20) begin
         step();
         n++;
      end
      if (!v_o) chk("v_o_timeout", n, 0);
   endtask

   task automatic drain();
      int n = 0;
      yumi_mode = 0;
      while ((inflight_o != 0 || v_o) && n < 60) begin
         step();
         n++;
      end
      step();
      chk("drain_inflight", inflight_o, 0);
      chk("drain_v", v_o, 0);
      chk("drain_queue", exp_q.size(), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int w, ac, n, base;
      logic [W-1:0] rx, ry;
      logic [2*W-1:0] za;

      reset_n_i = 1'b0; v_i = 1'b1; x_i = '0; y_i = '0; signed_i = 1'b0; yumi_i = 1'b0;

      // reset / idle
      repeat (3) step();
      chk("rst_ready", ready_o, 0);
      chk("rst_en", mul_en_o, 0);
      chk("rst_v", v_o, 0);
      chk("rst_z", z_o, 0);
      chk("rst_inflight", inflight_o, 0);
      v_i = 1'b0;
      reset_n_i = 1'b1;
      #1;
      chk("post_rst_ready", ready_o, 1);
      mon_en = 1;

      // single op latency
      yumi_mode = 0;
      step();
      send_op(7, 9, 1'b0, w, ac);
      wait_vo(n);
      chk("latency", cyc - ac, PIPE + 1);
      chk("single_z", z_o, 63);
      step();
      chk("single_v_drop", v_o, 0);

      // signed vs unsigned interpretation of the same bits
      send_op(~128'd2, 5, 1'b1, w, ac);
      wait_vo(n);
      chk("signed_z", z_o, ~256'd14);
      step();
      send_op(~128'd2, 5, 1'b0, w, ac);
      wait_vo(n);
      chk("unsigned_z", z_o, {128'd4, ~128'd14});
      step();

      // backpressure: fills after pipe depth + output register
      yumi_mode = 1;
      base = n_pop;
      n = n_acc;
      fork
         begin
            for (int i = 0; i < 6; i++) send_op(i, i + 1, 1'b0, w, ac);
         end
         begin
            repeat (12) step();
            chk("bp_accepts", n_acc - n, PIPE + 1);
            chk("bp_inflight", inflight_o, PIPE + 1);
            chk("bp_ready", ready_o, 0);
            yumi_mode = 3;
         end
      join
      n = 0;
      while (n_pop < base + 6 && n < 80) begin step(); n++; end
      chk("bp_pops", n_pop - base, 6);
      chk("bp_last", last_z, 30);
      drain();

      // bubble collapse with output held
      yumi_mode = 1;
      send_op(11, 13, 1'b0, w, ac);
      wait_vo(n);
      za = z_o;
      send_op(3, 4, 1'b0, w, ac);
      chk("bubble_wait_b", w, 0);
      send_op(5, 6, 1'b0, w, ac);
      chk("bubble_wait_c", w, 0);
      step();
      chk("bubble_full_ready", ready_o, 0);
      chk("bubble_inflight", inflight_o, 3);
      chk("bubble_z_held", z_o, za);
      drain();

      // reset mid-flight discards everything in the pipe
      yumi_mode = 1;
      send_op(100, 1, 1'b0, w, ac);
      send_op(200, 1, 1'b0, w, ac);
      send_op(300, 1, 1'b0, w, ac);
      reset_n_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      #1;
      chk("rst_mid_inflight", inflight_o, 0);
      base = n_pop;
      yumi_mode = 0;
      send_op(2, 3, 1'b0, w, ac);
      repeat (10) step();
      chk("rst_mid_pops", n_pop - base, 1);
      chk("rst_mid_z", last_z, 6);
      chk("rst_mid_inflight_end", inflight_o, 0);

      // random traffic with random consumer
      yumi_mode = 2;
      for (int i = 0; i < 40; i++) begin
         rx = {$urandom, $urandom, $urandom, $urandom};
         ry = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rx = rx >> $urandom_range(0, 127);
         send_op(rx, ry, 1'($urandom_range(0, 1)), w, ac);
         repeat ($urandom_range(0, 2)) step();
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
